// File: rtl/fnn_run_sequencer.sv
// rtl/fnn_run_sequencer.sv - loads FNN weights once, streams each image, then tallies classification results
// Optional result watchdog: define FNN_SEQ_TIMEOUT_EN.
module fnn_run_sequencer #(
  parameter int WEIGHT_WIDTH     = 16,
  parameter int PART_NO_WIDTH    = 7,
  parameter int INDATA_WIDTH     = 16,
  parameter int NO_OF_INPUTS     = 784,
  parameter int DEPTH            = 32030,
  parameter int NO_OF_IMAGES     = 140,
  parameter int IMAGES_PER_CLASS = 20,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic                                        clk,
  input  logic                                        restart,
  input  logic                                        go,
  output logic [$clog2(DEPTH)-1:0]                    wmem_addr,
  input  logic [WEIGHT_WIDTH+PART_NO_WIDTH-1:0]       wmem_data,
  output logic [$clog2(NO_OF_IMAGES*NO_OF_INPUTS)-1:0] imem_addr,
  input  logic [INDATA_WIDTH-1:0]                     imem_data,
  output logic                                        fnn_restart,
  output logic                                        load_weights,
  output logic                                        weight_valid,
  output logic                                        start_FNN,
  output logic                                        ready_in,
  output logic [WEIGHT_WIDTH+PART_NO_WIDTH-1:0]       weight_bus,
  output logic [INDATA_WIDTH-1:0]                     input_image,
  input  logic                                        FNN_ready,
  input  logic                                        FNN_ready_to_accept,
  input  logic                                        finish_FNN,
  input  logic [3:0]                                  max,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        timeout_flag,
  output logic [7:0]                                  no_of_images,
  output logic [7:0]                                  correctly_identified,
  output logic [3:0]                                  last_max
);

  localparam int WAW = $clog2(DEPTH);
  localparam int IAW = $clog2(NO_OF_IMAGES*NO_OF_INPUTS);
  localparam int PW  = $clog2(NO_OF_INPUTS+1);
  localparam int CW  = $clog2(IMAGES_PER_CLASS+1);

  typedef enum logic [2:0] {
    IDLE, WLOAD, WAIT_RDY, STREAM, WAIT_RES, NEXT, DONE
  } state_t;

  state_t         state;
  logic           issuing;       // addresses still being issued to the weight memory
  logic           fnn_restart_q;
  logic [IAW-1:0] image_base;
  logic [PW-1:0]  pix;
  logic [3:0]     label;
  logic [CW-1:0]  in_class;
  logic           transfer;
  logic           res_fire;
  logic           res_hit;
  logic [3:0]     res_max;

  assign transfer    = (state == STREAM) && ready_in && FNN_ready_to_accept;
  // Look one pixel ahead on a transfer so the next pixel lands on input_image right after it
  assign imem_addr   = image_base + IAW'(pix) + IAW'(transfer);
  assign weight_bus  = weight_valid ? wmem_data : '0;
  assign input_image = ready_in ? imem_data : '0;
  // The FNN is held in reset alongside the sequencer, and pulsed between images
  assign fnn_restart = restart | fnn_restart_q;

`ifdef FNN_SEQ_TIMEOUT_EN
  logic [$clog2(TIMEOUT_CYCLES+1)-1:0] tcnt;
  logic                                tmo;

  assign tmo = (state == WAIT_RES) && !finish_FNN &&
               (tcnt == ($clog2(TIMEOUT_CYCLES+1))'(TIMEOUT_CYCLES-1));

  // Watchdog on the result wait; the flag stays set until the next run starts
  always_ff @(posedge clk) begin
    if (restart) begin
      tcnt         <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == WAIT_RES && !finish_FNN) tcnt <= tcnt + 1'b1;
      else                                  tcnt <= '0;
      if (tmo)                                           timeout_flag <= 1'b1;
      else if ((state == IDLE || state == DONE) && go)   timeout_flag <= 1'b0;
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif

  // Result acceptance: a real finish, or (with the watchdog) a forced miss scored with max 4'hF
  always_comb begin
    res_fire = 1'b0;
    res_max  = max;
    res_hit  = (max == label);
    if (state == WAIT_RES) begin
      if (finish_FNN) begin
        res_fire = 1'b1;
      end
`ifdef FNN_SEQ_TIMEOUT_EN
      else if (tmo) begin
        res_fire = 1'b1;
        res_max  = 4'hF;
        res_hit  = 1'b0;
      end
`endif
    end
  end

  // Run sequencer: weight load, per-image streaming, result tally
  always_ff @(posedge clk) begin
    if (restart) begin
      state                <= IDLE;
      issuing              <= 1'b0;
      fnn_restart_q        <= 1'b0;
      wmem_addr            <= '0;
      image_base           <= '0;
      pix                  <= '0;
      label                <= '0;
      in_class             <= '0;
      load_weights         <= 1'b0;
      weight_valid         <= 1'b0;
      start_FNN            <= 1'b0;
      ready_in             <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      no_of_images         <= '0;
      correctly_identified <= '0;
      last_max             <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (go) begin
            state                <= WLOAD;
            busy                 <= 1'b1;
            done                 <= 1'b0;
            load_weights         <= 1'b1;
            issuing              <= 1'b1;
            wmem_addr            <= '0;
            image_base           <= '0;
            pix                  <= '0;
            label                <= '0;
            in_class             <= '0;
            no_of_images         <= '0;
            correctly_identified <= '0;
            last_max             <= '0;
          end
        end
        WLOAD: begin
          if (issuing) begin
            weight_valid <= 1'b1;
            if (wmem_addr == WAW'(DEPTH-1)) issuing   <= 1'b0;
            else                            wmem_addr <= wmem_addr + WAW'(1);
          end else begin
            // the final word is on weight_bus this cycle
            weight_valid <= 1'b0;
            load_weights <= 1'b0;
            wmem_addr    <= '0;
            state        <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (FNN_ready) begin
            state     <= STREAM;
            start_FNN <= 1'b1;
            ready_in  <= 1'b1;
          end
        end
        STREAM: begin
          if (transfer) begin
            pix <= pix + PW'(1);
            if (pix == PW'(NO_OF_INPUTS-1)) begin
              ready_in  <= 1'b0;
              start_FNN <= 1'b0;
              state     <= WAIT_RES;
            end
          end
        end
        WAIT_RES: begin
          if (res_fire) begin
            last_max     <= res_max;
            no_of_images <= no_of_images + 8'd1;
            if (res_hit) correctly_identified <= correctly_identified + 8'd1;
            if (in_class == CW'(IMAGES_PER_CLASS-1)) begin
              in_class <= '0;
              label    <= label + 4'd1;
            end else begin
              in_class <= in_class + CW'(1);
            end
            image_base    <= image_base + IAW'(NO_OF_INPUTS);
            pix           <= '0;
            fnn_restart_q <= 1'b1;
            state         <= NEXT;
          end
        end
        NEXT: begin
          fnn_restart_q <= 1'b0;
          if (no_of_images == 8'(NO_OF_IMAGES)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state     <= STREAM;
            start_FNN <= 1'b1;
            ready_in  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fnn_run_sequencer.sv
// tb/tb_fnn_run_sequencer.sv - scoreboard bench for fnn_run_sequencer with a behavioural FNN and memories
module tb_fnn_run_sequencer;

  localparam int WW = 16, PNW = 7, IW = 16;
  localparam int NI = 4, DEPTH = 8, NIMG = 6, IPC = 2, TO = 16;
  localparam int WAW = $clog2(DEPTH);
  localparam int IAW = $clog2(NIMG*NI);

  logic clk = 1'b0;
  logic restart, go;
  logic [WAW-1:0] wmem_addr;
  logic [WW+PNW-1:0] wmem_data;
  logic [IAW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic fnn_restart, load_weights, weight_valid, start_FNN, ready_in;
  logic [WW+PNW-1:0] weight_bus;
  logic [IW-1:0] input_image;
  logic FNN_ready, FNN_ready_to_accept, finish_FNN;
  logic [3:0] max;
  logic busy, done, timeout_flag;
  logic [7:0] no_of_images, correctly_identified;
  logic [3:0] last_max;

  fnn_run_sequencer #(
    .WEIGHT_WIDTH(WW), .PART_NO_WIDTH(PNW), .INDATA_WIDTH(IW), .NO_OF_INPUTS(NI),
    .DEPTH(DEPTH), .NO_OF_IMAGES(NIMG), .IMAGES_PER_CLASS(IPC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .restart(restart), .go(go),
    .wmem_addr(wmem_addr), .wmem_data(wmem_data),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .fnn_restart(fnn_restart), .load_weights(load_weights), .weight_valid(weight_valid),
    .start_FNN(start_FNN), .ready_in(ready_in), .weight_bus(weight_bus), .input_image(input_image),
    .FNN_ready(FNN_ready), .FNN_ready_to_accept(FNN_ready_to_accept), .finish_FNN(finish_FNN),
    .max(max), .busy(busy), .done(done), .timeout_flag(timeout_flag),
    .no_of_images(no_of_images), .correctly_identified(correctly_identified), .last_max(last_max)
  );

  always #5 clk = ~clk;

  logic [WW+PNW-1:0] wmem [DEPTH];
  logic [IW-1:0]     imem [NIMG*NI];

  always @(posedge clk) begin
    wmem_data <= wmem[wmem_addr];
    imem_data <= imem[imem_addr];
  end

  typedef struct { int n; int corr; logic [3:0] lm; } res_t;

  int checks = 0;
  int errors = 0;
  logic [WW+PNW-1:0] wq[$];
  logic [IW-1:0]     pq[$];
  res_t              rq[$];

  int xfers = 0, fin_cnt = 0, corr_model = 0, dly = 0, wv_cnt = 0;
  int max_mode = 0, acc_mode = 0, stuck_img = -1, pat_i = 0;
  bit stray_mode = 0, stray_done = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] prev_n = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=missing expected=present", name);
  endtask

  // Monitor: pop expected weights, pixels and per-image results as the DUT presents them
  always @(negedge clk) begin
    logic [WW+PNW-1:0] ew;
    logic [IW-1:0] ep;
    res_t r;
    if (!restart) begin
      if (weight_valid) begin
        wv_cnt++;
        if (wq.size() == 0) fail_now("weight_extra");
        else begin ew = wq.pop_front(); check("weight_word", weight_bus, ew); end
      end
      if (ready_in && FNN_ready_to_accept) begin
        xfers++;
        if (pq.size() == 0) fail_now("pixel_extra");
        else begin ep = pq.pop_front(); check("pixel", input_image, ep); end
      end
      if (no_of_images != prev_n) begin
        if (no_of_images != 8'd0) begin
          if (rq.size() == 0) fail_now("result_extra");
          else begin
            r = rq.pop_front();
            check("img_count", no_of_images, r.n);
            check("correct_count", correctly_identified, r.corr);
            check("last_max", last_max, r.lm);
          end
        end
        prev_n = no_of_images;
      end
    end
  end

  // Behavioural FNN: random handshakes; one result per NI accepted pixels, label = index / IPC
  always @(posedge clk) begin
    int lab;
    logic [3:0] m;
    #1;
    finish_FNN = 1'b0;
    FNN_ready = 1'($urandom_range(0, 1));
    if (acc_mode == 1) begin
      FNN_ready_to_accept = pat[pat_i];
      pat_i = (pat_i + 1) % 4;
    end else begin
      FNN_ready_to_accept = 1'($urandom_range(0, 1));
    end
    if (xfers / NI > fin_cnt) begin
      if (dly > 0) dly--;
      else begin
        lab = fin_cnt / IPC;
        if (fin_cnt == stuck_img) begin
          rq.push_back('{fin_cnt + 1, corr_model, 4'hF});
        end else begin
          m = (max_mode == 1) ? 4'd0 : 4'(lab);
          if (int'(m) == lab) corr_model++;
          max = m;
          finish_FNN = 1'b1;
          rq.push_back('{fin_cnt + 1, corr_model, m});
        end
        fin_cnt++;
        dly = $urandom_range(0, 3);
      end
    end else if (stray_mode && !stray_done && ready_in && (xfers % NI) == 1) begin
      max = 4'((fin_cnt) / IPC);
      finish_FNN = 1'b1;
      stray_done = 1'b1;
    end
  end

  task automatic start_run(input int mm, input int am, input int stuck, input bit stray, input bit hold);
    max_mode = mm; acc_mode = am; stuck_img = stuck; stray_mode = stray; stray_done = 0;
    xfers = 0; fin_cnt = 0; corr_model = 0; dly = 0; wv_cnt = 0; pat_i = 0;
    wq.delete(); pq.delete(); rq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back(wmem[i]);
    for (int i = 0; i < NIMG*NI; i++) pq.push_back(imem[i]);
    go = 1'b1;
    @(negedge clk);
    go = hold;
    check("busy_after_go", busy, 1'b1);
    check("cleared_images", no_of_images, 8'd0);
    check("cleared_correct", correctly_identified, 8'd0);
    check("cleared_done", done, 1'b0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    go = 1'b0;
    if (!done) fail_now("done_wait_bound");
  endtask

  task automatic final_checks(input int exp_c, input bit exp_to);
    check("final_done", done, 1'b1);
    check("final_busy", busy, 1'b0);
    check("final_images", no_of_images, NIMG);
    check("final_correct", correctly_identified, exp_c);
    check("weights_seen", wv_cnt, DEPTH);
    check("pixels_left", pq.size(), 0);
    check("results_left", rq.size(), 0);
    check("timeout_flag", timeout_flag, exp_to);
  endtask

  task automatic check_reset_outputs();
    check("rst_fnn_restart", fnn_restart, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_load", load_weights, 1'b0);
    check("rst_wvalid", weight_valid, 1'b0);
    check("rst_start", start_FNN, 1'b0);
    check("rst_ready_in", ready_in, 1'b0);
    check("rst_wbus", weight_bus, 0);
    check("rst_image", input_image, 0);
    check("rst_waddr", wmem_addr, 0);
    check("rst_iaddr", imem_addr, 0);
    check("rst_images", no_of_images, 0);
    check("rst_correct", correctly_identified, 0);
    check("rst_last_max", last_max, 0);
    check("rst_timeout", timeout_flag, 1'b0);
  endtask

  initial begin
    int n;
    restart = 1'b1; go = 1'b0; FNN_ready = 1'b0; FNN_ready_to_accept = 1'b0;
    finish_FNN = 1'b0; max = 4'd0;
    for (int i = 0; i < DEPTH; i++) wmem[i] = 23'($urandom);
    for (int i = 0; i < NIMG*NI; i++) imem[i] = {8'(i), 8'($urandom)};
    repeat (3) @(negedge clk);
    check_reset_outputs();
    restart = 1'b0;
    @(negedge clk);
    check("post_rst_fnn_restart", fnn_restart, 1'b0);

    // run with random handshakes, FNN always right
    start_run(0, 0, -1, 0, 0);
    wait_done();
    final_checks(NIMG, 0);
    repeat (3) @(negedge clk);
    check("done_held", done, 1'b1);
    check("images_held", no_of_images, NIMG);

    // accept pattern 1,0,0,1 restarted from DONE
    start_run(0, 1, -1, 0, 0);
    wait_done();
    final_checks(NIMG, 0);

    // FNN always answers class 0
    start_run(1, 0, -1, 0, 0);
    wait_done();
    final_checks(2, 0);

    // restart in the middle of the weight load, then a clean run
    start_run(0, 0, -1, 0, 0);
    n = 0;
    while (wv_cnt < 3 && n < 100) begin @(negedge clk); n++; end
    if (wv_cnt < 3) fail_now("third_weight_bound");
    restart = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    restart = 1'b0;
    @(negedge clk);
    check("idle_after_rst", busy, 1'b0);
    start_run(0, 0, -1, 0, 0);
    wait_done();
    final_checks(NIMG, 0);

`ifdef FNN_SEQ_TIMEOUT_EN
    // image 2 never reports; watchdog scores it as a miss
    start_run(0, 0, 2, 0, 0);
    wait_done();
    final_checks(NIMG - 1, 1);
    check("timeout_last_img_max", last_max, 4'(((NIMG-1)/IPC)));
`endif

    // go held high while busy plus a stray finish mid-stream
    start_run(0, 0, -1, 1, 1);
    check("timeout_cleared", timeout_flag, 1'b0);
    wait_done();
    final_checks(NIMG, 0);
    check("stray_sent", stray_done, 1'b1);
    @(negedge clk);
    check("no_rerun_after_done", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_bound actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/fnn_run_sequencer.md
FNN_RUN_SEQUENCER -- requirements
Module: fnn_run_sequencer

Interface
REQ-001 Parameter WEIGHT_WIDTH, 16, weight field width.
REQ-002 Parameter PART_NO_WIDTH, 7, part-number field width.
REQ-003 Parameter INDATA_WIDTH, 16, pixel width.
REQ-004 Parameter NO_OF_INPUTS, 784, pixels per image.
REQ-005 Parameter DEPTH, 32030, weight/bias words per load.
REQ-006 Parameter NO_OF_IMAGES, 140, images per run.
REQ-007 Parameter IMAGES_PER_CLASS, 20, consecutive images sharing one label, labels starting at 0.
REQ-008 Parameter TIMEOUT_CYCLES, 4096, result watchdog limit.
REQ-009 clk  in  1  single clock; all logic on rising edge.
REQ-010 restart  in  1  synchronous, active-high reset.
REQ-011 go  in  1  start-run pulse.
REQ-012 wmem_addr  out  clog2(DEPTH)  weight memory address; wmem_data  in  WEIGHT_WIDTH+PART_NO_WIDTH  read data.
REQ-013 imem_addr  out  clog2(NO_OF_IMAGES*NO_OF_INPUTS)  image memory address; imem_data  in  INDATA_WIDTH  read data.
REQ-014 fnn_restart, load_weights, weight_valid, start_FNN, ready_in  out  1 each  FNN controls; weight_bus  out  WEIGHT_WIDTH+PART_NO_WIDTH; input_image  out  INDATA_WIDTH.
REQ-015 FNN_ready, FNN_ready_to_accept, finish_FNN  in  1 each; max  in  4  FNN class result.
REQ-016 busy, done, timeout_flag  out  1 each; no_of_images, correctly_identified  out  8 each; last_max  out  4.

Function
REQ-017 States IDLE, WLOAD, WAIT_RDY, STREAM, WAIT_RES, NEXT, DONE; IDLE->WLOAD on go.
REQ-018 Both memories: synchronous read, 1-cycle latency (address in cycle N, data in N+1).
REQ-019 WLOAD: load_weights=1; wmem_addr steps 0..DEPTH-1, one per cycle; weight_bus=wmem_data with weight_valid=1 exactly DEPTH consecutive cycles, starting cycle after WLOAD entry.
REQ-020 Cycle after last weight_valid: load_weights=0, weight_valid=0, ->WAIT_RDY; FNN_ready=1 ->STREAM.
REQ-021 STREAM: start_FNN=1, ready_in=1; pixel transfer = cycle with ready_in=1 and FNN_ready_to_accept=1.
REQ-022 imem_addr = image_base+pixel index, advanced combinationally on transfer so next pixel is on input_image the following cycle; input_image held while FNN_ready_to_accept=0.
REQ-023 After NO_OF_INPUTS transfers: ready_in=0 ->WAIT_RES; no transfer beyond NO_OF_INPUTS.
REQ-024 finish_FNN outside WAIT_RES ignored.
REQ-025 WAIT_RES + finish_FNN: last_max<=max; no_of_images+1; correctly_identified+1 if max==label; ->NEXT.
REQ-026 label = image_index/IMAGES_PER_CLASS, kept as counter + in-class counter, no divider.
REQ-027 NEXT: fnn_restart=1 one cycle; image_base+=NO_OF_INPUTS; ->STREAM, or ->DONE after NO_OF_IMAGES images; weights not reloaded.
REQ-028 busy=1 in all states except IDLE/DONE; go while busy ignored.
REQ-029 DONE: done=1, counters/last_max held; go clears counters, done, timeout_flag, ->WLOAD.
REQ-030 go and restart same cycle: restart wins.

Reset
REQ-031 restart=1 (any state, incl. mid-load/mid-stream) -> IDLE next edge.
REQ-032 Reset values: all outputs 0; addresses 0; counters 0; label 0; fnn_restart=1 during reset so FNN is also reset.

Configuration
REQ-033 Macro FNN_SEQ_TIMEOUT_EN defined: WAIT_RES cycle counter; TIMEOUT_CYCLES cycles without finish_FNN -> image counted, not correct, last_max=4'hF, timeout_flag=1 (sticky), ->NEXT.
REQ-034 FNN_SEQ_TIMEOUT_EN undefined: no watchdog, WAIT_RES waits indefinitely, timeout_flag tied 0.

Verification (DEPTH=8, NO_OF_INPUTS=4, NO_OF_IMAGES=6, IMAGES_PER_CLASS=2, TIMEOUT_CYCLES=16)
REQ-035 go, model FNN returns max=image_index/2 -> 8 consecutive weight_valid words match memory 0..7; done=1, no_of_images=6, correctly_identified=6.
REQ-036 FNN_ready_to_accept toggled 1,0,0,1 per cycle -> exactly 4 pixels/image, in address order, no duplicates, none dropped.
REQ-037 Model returns max=0 always -> correctly_identified=2 (images 0,1 only).
REQ-038 restart asserted at 3rd weight word, then go -> outputs all reset values next cycle; full 8-word reload from address 0.
REQ-039 FNN_SEQ_TIMEOUT_EN, image 2 never finishes -> after 16 cycles last_max=4'hF, timeout_flag=1, run completes, no_of_images=6, correctly_identified=5.
REQ-040 go held high through DONE, finish_FNN pulsed during STREAM -> no restart while busy, stray finish ignored, counts unchanged.
